// File: rtl/map_rom_arbiter_pkg.sv
// rtl/map_rom_arbiter_pkg.sv - shared widths, grant encoding and grant policy for map_rom_arbiter
package map_rom_arbiter_pkg;

  localparam int MAP_WIDTH_BITS_DEF  = 4;
  localparam int MAP_HEIGHT_BITS_DEF = 4;
  localparam int MAX_STARVE_DEF      = 3;
  localparam int STARVE_W            = 4;
  localparam int STALL_W             = 16;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_T    = 2'd1,
    SEL_O    = 2'd2
  } gnt_sel_e;

  // Overlay has pixel-timing priority; the tracer only wins alone or once starved.
  function automatic gnt_sel_e pick_grant(input logic t_req, input logic o_req,
                                          input logic starve_max);
    gnt_sel_e sel;
    sel = SEL_NONE;
    if (t_req && (!o_req || starve_max)) begin
      sel = SEL_T;
    end else if (o_req) begin
      sel = SEL_O;
    end
    return sel;
  endfunction

endpackage

// File: rtl/map_arb_starve.sv
// rtl/map_arb_starve.sv - saturating tracer starve counter with MAX_STARVE compare
module map_arb_starve
  import map_rom_arbiter_pkg::*;
#(
  parameter int MAX_STARVE = MAX_STARVE_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic t_req,
  input  logic t_gnt,
  output logic starve_max
);

  logic [STARVE_W-1:0] count;

  // Count refused tracer cycles; any tracer grant or dropped request restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (!t_req || t_gnt) begin
      count <= '0;
    end else if (count != STARVE_W'(MAX_STARVE)) begin
      count <= count + 1'b1;
    end
  end

  assign starve_max = (count == STARVE_W'(MAX_STARVE));

endmodule

// File: rtl/map_rom_arbiter.sv
// rtl/map_rom_arbiter.sv - shares one map ROM between tracer and overlay (optional stats: MAP_ARB_STATS_EN)
module map_rom_arbiter
  import map_rom_arbiter_pkg::*;
#(
  parameter int MAP_WIDTH_BITS  = MAP_WIDTH_BITS_DEF,
  parameter int MAP_HEIGHT_BITS = MAP_HEIGHT_BITS_DEF,
  parameter int MAX_STARVE      = MAX_STARVE_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_t_req,
  input  logic [MAP_WIDTH_BITS-1:0]  i_t_col,
  input  logic [MAP_HEIGHT_BITS-1:0] i_t_row,
  output logic                       o_t_gnt,
  output logic                       o_t_valid,
  output logic                       o_t_val,
  input  logic                       i_o_req,
  input  logic [MAP_WIDTH_BITS-1:0]  i_o_col,
  input  logic [MAP_HEIGHT_BITS-1:0] i_o_row,
  output logic                       o_o_gnt,
  output logic                       o_o_valid,
  output logic                       o_o_val,
  output logic [MAP_WIDTH_BITS-1:0]  o_map_col,
  output logic [MAP_HEIGHT_BITS-1:0] o_map_row,
`ifdef MAP_ARB_STATS_EN
  input  logic                       i_frame_start,
  output logic [STALL_W-1:0]         o_stall_count,
`endif
  input  logic                       i_map_val
);

  gnt_sel_e sel;
  logic     starve_max;
  logic     t_valid_q;
  logic     t_val_q;
  logic     o_valid_q;
  logic     o_val_q;

  map_arb_starve #(
    .MAX_STARVE (MAX_STARVE)
  ) u_starve (
    .clk        (clk),
    .reset      (reset),
    .t_req      (i_t_req),
    .t_gnt      (o_t_gnt),
    .starve_max (starve_max)
  );

  // Grant and ROM address are pure functions of the requests and starve state; nothing is granted during reset.
  always_comb begin
    sel       = SEL_NONE;
    o_map_col = '0;
    o_map_row = '0;
    if (!reset) begin
      sel = pick_grant(i_t_req, i_o_req, starve_max);
    end
    case (sel)
      SEL_T: begin
        o_map_col = i_t_col;
        o_map_row = i_t_row;
      end
      SEL_O: begin
        o_map_col = i_o_col;
        o_map_row = i_o_row;
      end
      default: begin
        o_map_col = '0;
        o_map_row = '0;
      end
    endcase
  end

  assign o_t_gnt = (sel == SEL_T);
  assign o_o_gnt = (sel == SEL_O);

  // Capture the ROM output at the end of each grant cycle; data holds until the same requester is granted again.
  always_ff @(posedge clk) begin
    if (reset) begin
      t_valid_q <= 1'b0;
      t_val_q   <= 1'b0;
      o_valid_q <= 1'b0;
      o_val_q   <= 1'b0;
    end else begin
      t_valid_q <= o_t_gnt;
      o_valid_q <= o_o_gnt;
      if (o_t_gnt) begin
        t_val_q <= i_map_val;
      end
      if (o_o_gnt) begin
        o_val_q <= i_map_val;
      end
    end
  end

  // A reset arriving right after a grant must hide that grant's pulse and data immediately.
  assign o_t_valid = t_valid_q & ~reset;
  assign o_t_val   = t_val_q & ~reset;
  assign o_o_valid = o_valid_q & ~reset;
  assign o_o_val   = o_val_q & ~reset;

`ifdef MAP_ARB_STATS_EN
  logic               stall;
  logic [STALL_W-1:0] stall_count;

  assign stall = (i_t_req & ~o_t_gnt) | (i_o_req & ~o_o_gnt);

  // Saturating per-frame stall counter; frame start clears ahead of any increment.
  always_ff @(posedge clk) begin
    if (reset || i_frame_start) begin
      stall_count <= '0;
    end else if (stall && (stall_count != {STALL_W{1'b1}})) begin
      stall_count <= stall_count + 1'b1;
    end
  end

  assign o_stall_count = stall_count;
`endif

endmodule

// File: tb/tb_map_rom_arbiter.sv
// tb/tb_map_rom_arbiter.sv - directed vector bench for map_rom_arbiter (stats block under MAP_ARB_STATS_EN)
module tb_map_rom_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       t_req, o_req;
  logic [3:0] t_col, t_row, o_col, o_row;
  logic       t_gnt, t_valid, t_val;
  logic       o_gnt, o_valid, o_val;
  logic [3:0] map_col, map_row;
  logic       map_val;
`ifdef MAP_ARB_STATS_EN
  logic        frame_start;
  logic [15:0] stall_count;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  map_rom_arbiter #(
    .MAP_WIDTH_BITS  (4),
    .MAP_HEIGHT_BITS (4),
    .MAX_STARVE      (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_t_req       (t_req),
    .i_t_col       (t_col),
    .i_t_row       (t_row),
    .o_t_gnt       (t_gnt),
    .o_t_valid     (t_valid),
    .o_t_val       (t_val),
    .i_o_req       (o_req),
    .i_o_col       (o_col),
    .i_o_row       (o_row),
    .o_o_gnt       (o_gnt),
    .o_o_valid     (o_valid),
    .o_o_val       (o_val),
    .o_map_col     (map_col),
    .o_map_row     (map_row),
`ifdef MAP_ARB_STATS_EN
    .i_frame_start (frame_start),
    .o_stall_count (stall_count),
`endif
    .i_map_val     (map_val)
  );

  // ROM contents: bit = ((col + row) mod 3 == 2)
  function automatic logic rom_bit(input logic [3:0] c, input logic [3:0] r);
    int s;
    s = int'(c) + int'(r);
    return (s % 3) == 2;
  endfunction

  assign map_val = rom_bit(map_col, map_row);

  typedef struct {
    logic       t_req;
    logic [3:0] t_col;
    logic [3:0] t_row;
    logic       o_req;
    logic [3:0] o_col;
    logic [3:0] o_row;
    logic       e_t_gnt;
    logic       e_o_gnt;
    logic [3:0] e_col;
    logic [3:0] e_row;
    logic       e_t_valid;
    logic       e_t_val;
    logic       e_o_valid;
    logic       e_o_val;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic drive(input logic tr, input logic [3:0] tc, input logic [3:0] trw,
                       input logic orq, input logic [3:0] oc, input logic [3:0] orw);
    t_req = tr; t_col = tc; t_row = trw;
    o_req = orq; o_col = oc; o_row = orw;
  endtask

  initial begin
    //            treq tcol  trow  oreq ocol  orow  tg og col   row   tv tval ov oval
    vecs[0]  = '{1'b1, 4'd5, 4'd9, 1'b0, 4'd0, 4'd0, 1, 0, 4'd5, 4'd9, 0, 0, 0, 0};
    vecs[1]  = '{1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 0, 0, 4'd0, 4'd0, 1, 1, 0, 0};
    vecs[2]  = '{1'b0, 4'd0, 4'd0, 1'b1, 4'd1, 4'd1, 0, 1, 4'd1, 4'd1, 0, 1, 0, 0};
    vecs[3]  = '{1'b0, 4'd0, 4'd0, 1'b1, 4'd3, 4'd0, 0, 1, 4'd3, 4'd0, 0, 1, 1, 1};
    vecs[4]  = '{1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 0, 0, 4'd0, 4'd0, 0, 1, 1, 0};
    vecs[5]  = '{1'b1, 4'd2, 4'd0, 1'b1, 4'd4, 4'd1, 0, 1, 4'd4, 4'd1, 0, 1, 0, 0};
    vecs[6]  = '{1'b1, 4'd2, 4'd0, 1'b1, 4'd4, 4'd1, 0, 1, 4'd4, 4'd1, 0, 1, 1, 1};
    vecs[7]  = '{1'b1, 4'd7, 4'd0, 1'b1, 4'd4, 4'd1, 0, 1, 4'd4, 4'd1, 0, 1, 1, 1};
    vecs[8]  = '{1'b1, 4'd7, 4'd0, 1'b1, 4'd4, 4'd1, 1, 0, 4'd7, 4'd0, 0, 1, 1, 1};
    vecs[9]  = '{1'b1, 4'd7, 4'd0, 1'b1, 4'd4, 4'd1, 0, 1, 4'd4, 4'd1, 1, 0, 0, 1};
    vecs[10] = '{1'b1, 4'd7, 4'd0, 1'b1, 4'd4, 4'd1, 0, 1, 4'd4, 4'd1, 0, 0, 1, 1};
    vecs[11] = '{1'b1, 4'd7, 4'd0, 1'b1, 4'd4, 4'd1, 0, 1, 4'd4, 4'd1, 0, 0, 1, 1};
    vecs[12] = '{1'b1, 4'd7, 4'd0, 1'b1, 4'd4, 4'd1, 1, 0, 4'd7, 4'd0, 0, 0, 1, 1};
    vecs[13] = '{1'b1, 4'd7, 4'd0, 1'b1, 4'd4, 4'd1, 0, 1, 4'd4, 4'd1, 1, 0, 0, 1};
    vecs[14] = '{1'b1, 4'd2, 4'd0, 1'b0, 4'd0, 4'd0, 1, 0, 4'd2, 4'd0, 0, 0, 1, 1};
    vecs[15] = '{1'b1, 4'd1, 4'd0, 1'b0, 4'd0, 4'd0, 1, 0, 4'd1, 4'd0, 1, 1, 0, 1};
    vecs[16] = '{1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 0, 0, 4'd0, 4'd0, 1, 0, 0, 1};
    vecs[17] = '{1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 0, 0, 4'd0, 4'd0, 0, 0, 0, 1};

    reset = 1'b1;
`ifdef MAP_ARB_STATS_EN
    frame_start = 1'b0;
`endif
    drive(1, 4'd5, 4'd9, 1, 4'd3, 4'd3);

    // reset held 3 cycles with both requesting
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("rst%0d_t_gnt", k), t_gnt, 0);
      check($sformatf("rst%0d_o_gnt", k), o_gnt, 0);
      check($sformatf("rst%0d_valids", k), {t_valid, o_valid}, 0);
      check($sformatf("rst%0d_vals", k), {t_val, o_val}, 0);
      check($sformatf("rst%0d_addr", k), {map_col, map_row}, 0);
    end
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].t_req, vecs[i].t_col, vecs[i].t_row,
            vecs[i].o_req, vecs[i].o_col, vecs[i].o_row);
      @(negedge clk);
      check($sformatf("v%0d_t_gnt", i), t_gnt, vecs[i].e_t_gnt);
      check($sformatf("v%0d_o_gnt", i), o_gnt, vecs[i].e_o_gnt);
      check($sformatf("v%0d_col", i), map_col, vecs[i].e_col);
      check($sformatf("v%0d_row", i), map_row, vecs[i].e_row);
      check($sformatf("v%0d_t_valid", i), t_valid, vecs[i].e_t_valid);
      check($sformatf("v%0d_t_val", i), t_val, vecs[i].e_t_val);
      check($sformatf("v%0d_o_valid", i), o_valid, vecs[i].e_o_valid);
      check($sformatf("v%0d_o_val", i), o_val, vecs[i].e_o_val);
      @(posedge clk); #1;
    end

    // starve counter must be cleared by reset: build up starve, reset, then expect O,O,O,T,...
    drive(1, 4'd2, 4'd0, 1, 4'd4, 4'd1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("pre_rst%0d_o_gnt", k), o_gnt, 1);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_gnts", {t_gnt, o_gnt}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("cont%0d_t_gnt", k), t_gnt, (k % 4) == 3);
      check($sformatf("cont%0d_o_gnt", k), o_gnt, (k % 4) != 3);
      check($sformatf("cont%0d_t_valid", k), t_valid, (k > 0) && ((k - 1) % 4 == 3));
      @(posedge clk); #1;
    end

    // reset in the cycle right after a T grant
    drive(1, 4'd5, 4'd9, 0, 4'd0, 4'd0);
    @(negedge clk);
    check("rmr_grant", t_gnt, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rmr_t_valid", t_valid, 0);
    check("rmr_t_val", t_val, 0);
    check("rmr_t_gnt", t_gnt, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rmr_resume_gnt", t_gnt, 1);
    check("rmr_resume_valid", t_valid, 0);
    @(posedge clk); #1;
    drive(0, 4'd0, 4'd0, 0, 4'd0, 4'd0);
    @(negedge clk);
    check("rmr_post_valid", t_valid, 1);
    check("rmr_post_val", t_val, 1);
    @(posedge clk); #1;

`ifdef MAP_ARB_STATS_EN
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    @(negedge clk);
    check("stats_cleared", stall_count, 0);
    drive(1, 4'd2, 4'd0, 1, 4'd4, 4'd1);
    repeat (10) @(posedge clk);
    #1;
    drive(0, 4'd0, 4'd0, 0, 4'd0, 4'd0);
    @(negedge clk);
    check("stats_10", stall_count, 10);
    @(posedge clk); #1;
    frame_start = 1'b1;
    drive(1, 4'd2, 4'd0, 1, 4'd4, 4'd1);
    @(posedge clk); #1;
    frame_start = 1'b0;
    drive(0, 4'd0, 4'd0, 0, 4'd0, 4'd0);
    @(negedge clk);
    check("stats_clear_prio", stall_count, 0);
    drive(1, 4'd2, 4'd0, 1, 4'd4, 4'd1);
    repeat (70000) @(posedge clk);
    #1;
    drive(0, 4'd0, 4'd0, 0, 4'd0, 4'd0);
    @(negedge clk);
    check("stats_sat", stall_count, 65535);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
